sfp_ctrl: RTL and testbench
===========================

# sfp_ctrl

Sequencer for the SFP lane bank that sits between the output FIFO (OFIFO) of the systolic array and the psum SRAM write port. It pops partial-sum vectors from the OFIFO and drives the shared `acc_en`/`flush_en` strobes of all `sfp_lane` instances. After `acc_len` vectors it flushes the accumulated result and issues one psum-SRAM write per output tile, for `num_out` tiles, then signals `done`.

## Interface
- `CNT_W`, default 8: width of the accumulation-length config and counter.
- `ADDR_W`, default 11: width of the output-tile count and psum SRAM address.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `start` in 1: one-cycle pulse; latches config and begins a job (honoured in IDLE only).
- `abort` in 1: synchronous job cancel, honoured in RUN/WAIT.
- `cfg_acc_len` in CNT_W: vectors accumulated per output; 0 treated as 1.
- `cfg_num_out` in ADDR_W: output tiles per job.
- `cfg_base_addr` in ADDR_W: psum SRAM address of tile 0.
- `ofifo_valid` in 1: OFIFO head holds a valid vector.
- `ofifo_rd` out 1: pop OFIFO head this cycle.
- `acc_en` out 1: to all lanes; accumulate the OFIFO head this cycle.
- `flush_en` out 1: to all lanes; emit and clear the sum.
- `out_valid` out 1: lane `data_out` is valid; write it to the SRAM this cycle.
- `out_addr` out ADDR_W: psum SRAM write address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - On `start`, latch `acc_len = max(cfg_acc_len,1)`, `num_out`, `base_addr`; clear `acc_cnt` and `out_cnt`.
  - `cfg_num_out == 0` → DONE, else → RUN.
- RUN, combinational strobes:
  - `ofifo_rd = acc_en = ofifo_valid`.
  - `flush_en = ofifo_valid && acc_cnt == acc_len-1`.
  - No OFIFO-valid cycle means no strobes and counters hold (bubble).
- RUN, on a beat (`ofifo_valid`):
  - Non-final beat: `acc_cnt++`.
  - Final beat: `acc_cnt ← 0`; `out_cnt++`.
  - If `out_cnt` was `num_out-1`, go to WAIT; else stay in RUN.
- WAIT: one cycle, so the last `out_valid` is issued → DONE.
- DONE: `done=1` for one cycle → IDLE.
- Output write: `out_valid` is registered, high the cycle after each flush beat. `out_addr` is registered as `base_addr + out_cnt` (pre-increment value) and is modulo 2^ADDR_W (wraps).
- Abort in RUN/WAIT:
  - Next cycle, assert `flush_en=1` with `acc_en=0` for one cycle, clearing every lane's `psum_q`.
  - No `out_valid`, no `done`; → IDLE.
  - A pending `out_valid` from a flush beat in the abort cycle is still issued.
  - `abort` has priority over a beat in the same cycle: no `ofifo_rd`/`acc_en` that cycle.
- Ignored inputs: `start` outside IDLE; `abort` in IDLE/DONE.
- Reset (async, any state): state → IDLE; counters 0.

## Timing
- Reset values: `ofifo_rd`, `acc_en`, `flush_en`, `out_valid`, `busy`, `done` = 0; `out_addr` = 0.
- `ofifo_rd`, `acc_en` and `flush_en` are Mealy outputs, same cycle as `ofifo_valid`. The lane sees `data_in` and the strobe at the same edge.
- Flush-to-write latency: `out_valid` is exactly 1 cycle after the flush beat, matching the lane's registered `data_out`.
- Back-to-back flushes with `acc_len=1` give `out_valid` on consecutive cycles.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Minimum job length: `start` → `done` is `num_out*acc_len + 3` cycles with no bubbles.

## Structure
- Shared package `sfp_pkg`: state encoding enum (IDLE/RUN/WAIT/DONE), default `CNT_W`/`ADDR_W`.
- One sub-module `sfp_beat_counter` (`acc_cnt` with terminal-count flag, parameterised width), instantiated for `acc_cnt`. `out_cnt` reuses it with width ADDR_W.
- Lanes are not instantiated here; top-level fans out `acc_en`/`flush_en`.

## Test plan
- Reset mid-RUN (`acc_cnt=2`): all outputs return to 0 asynchronously. A new `start` then runs a full job correctly.
- `acc_len=4`, `num_out=3`, base=0x010, continuous valid:
  - `flush_en` on beats 4, 8, 12.
  - `out_valid` at 0x010, 0x011, 0x012.
  - `done` at cycle 15 after start.
- `acc_len=3`, `num_out=1`, valid pattern 1,0,1,0,1: flush only on the 3rd valid beat; counters hold during bubbles.
- `cfg_acc_len=0`, `num_out=2`: behaves as `acc_len=1`, flushing every beat with back-to-back `out_valid`. `num_out=0`: `done` in 2 cycles, no strobes.
- Abort after 2 of 4 beats: one `flush_en` without `acc_en`, no `out_valid`/`done`, IDLE next. Lanes read 0 on the next job's first flush minus new data.
- base=0x7FF, `num_out=2`, ADDR_W=11: addresses 0x7FF then 0x000. `start` during RUN is ignored.

Source files
------------

// File: rtl/sfp_pkg.sv
// sfp_pkg: shared definitions for the SFP lane-bank sequencer.
//   - sfp_state_t : sequencer state encoding (IDLE/RUN/WAIT/DONE)
//   - DEF_CNT_W   : default width of the accumulation-length config/counter
//   - DEF_ADDR_W  : default width of the tile count and psum SRAM address
package sfp_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } sfp_state_t;

endpackage

// File: rtl/sfp_beat_counter.sv
// sfp_beat_counter: wrapping up-counter with a terminal-count flag.
//   clk, reset : clock and asynchronous active-low reset
//   clr        : synchronous clear to 0 (priority over inc)
//   inc        : advance by one; wraps to 0 when already at last
//   last       : terminal value
//   cnt        : current count
//   tc         : cnt == last (combinational)
module sfp_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sfp_ctrl.sv
// sfp_ctrl: sequencer between the systolic-array OFIFO and the psum SRAM.
// Pops partial-sum vectors, strobes acc_en/flush_en to every sfp_lane, and
// issues one psum write per output tile after acc_len accumulated vectors.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : one-cycle job start (IDLE only), latches cfg_*
//   abort          : cancel job (RUN/WAIT only); lanes get a clearing flush
//   cfg_acc_len    : vectors per output (0 behaves as 1)
//   cfg_num_out    : output tiles per job
//   cfg_base_addr  : psum address of tile 0
//   ofifo_valid    : OFIFO head valid
//   ofifo_rd       : pop OFIFO head (same cycle as ofifo_valid)
//   acc_en         : lanes accumulate OFIFO head
//   flush_en       : lanes emit and clear their sums
//   out_valid      : lane data_out valid, write it to psum SRAM
//   out_addr       : psum SRAM write address (wraps modulo 2^ADDR_W)
//   busy           : job in progress
//   done           : one-cycle job-complete pulse
module sfp_ctrl
  import sfp_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_acc_len,
  input  logic [ADDR_W-1:0] cfg_num_out,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  output logic              acc_en,
  output logic              flush_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  sfp_state_t        state;
  logic [CNT_W-1:0]  acc_last;
  logic [ADDR_W-1:0] out_last;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  acc_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              acc_tc;
  logic              out_tc;
  logic              abort_flush;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_p1;
  logic [ADDR_W-1:0] out_addr_p1;

  logic start_ok;
  logic abort_ok;
  logic beat;
  logic final_beat;
  logic cnt_clr;

  assign start_ok   = (state == ST_IDLE) && start;
  assign abort_ok   = abort && ((state == ST_RUN) || (state == ST_WAIT));
  // Abort wins over a beat arriving in the same cycle.
  assign beat       = (state == ST_RUN) && ofifo_valid && !abort;
  assign final_beat = beat && acc_tc;
  assign cnt_clr    = start_ok || abort_ok;

  // Mealy strobes: the lane sees data_in and the strobe at the same edge.
  assign ofifo_rd = beat;
  assign acc_en   = beat;
  assign flush_en = final_beat || abort_flush;

  assign out_valid = out_valid_p1;
  assign out_addr  = out_addr_p1;
  assign busy      = busy_q;
  assign done      = done_q;

  sfp_beat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (beat),
    .last  (acc_last),
    .cnt   (acc_cnt),
    .tc    (acc_tc)
  );

  sfp_beat_counter #(.W(ADDR_W)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (final_beat),
    .last  (out_last),
    .cnt   (out_cnt),
    .tc    (out_tc)
  );

  // Job configuration, held as terminal values so the counters compare directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_last  <= '0;
      out_last  <= '0;
      base_addr <= '0;
    end else if (start_ok) begin
      acc_last  <= (cfg_acc_len == '0) ? '0 : cfg_acc_len - 1'b1;
      out_last  <= cfg_num_out - 1'b1;
      base_addr <= cfg_base_addr;
    end
  end

  // Sequencer. busy stays high through the done pulse and drops after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_flush <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      abort_flush <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            state  <= (cfg_num_out == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy_q      <= 1'b0;
            abort_flush <= 1'b1;
            state       <= ST_IDLE;
          end else if (final_beat && out_tc) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy_q      <= 1'b0;
            abort_flush <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: write strobe/address one cycle after the flush beat,
  // aligned with the lanes' registered data_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_p1 <= 1'b0;
      out_addr_p1  <= '0;
    end else begin
      out_valid_p1 <= final_beat;
      if (final_beat) out_addr_p1 <= base_addr + out_cnt;
    end
  end

endmodule

// File: tb/tb_sfp_ctrl.sv
// tb_sfp_ctrl: directed bench for sfp_ctrl with an address scoreboard.
module tb_sfp_ctrl;

  localparam int CNT_W  = 8;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  cfg_acc_len;
  logic [ADDR_W-1:0] cfg_num_out;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic              ofifo_valid;
  logic              ofifo_rd;
  logic              acc_en;
  logic              flush_en;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] mon_exp;

  always #5 clk = ~clk;

  sfp_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_acc_len   (cfg_acc_len),
    .cfg_num_out   (cfg_num_out),
    .cfg_base_addr (cfg_base_addr),
    .ofifo_valid   (ofifo_valid),
    .ofifo_rd      (ofifo_rd),
    .acc_en        (acc_en),
    .flush_en      (flush_en),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid must match the next expected write address.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_addr", 32'(out_addr), 32'(mon_exp));
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] al, input logic [ADDR_W-1:0] no,
                          input logic [ADDR_W-1:0] base);
    cfg_acc_len   = al;
    cfg_num_out   = no;
    cfg_base_addr = base;
    ofifo_valid   = 1'b0;
    abort         = 1'b0;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic drive(input logic v, input logic ab, input logic e_rd, input logic e_fl,
                       input string tag);
    ofifo_valid = v;
    abort       = ab;
    @(negedge clk);
    check({tag, "_rd_acc"}, 32'({ofifo_rd, acc_en}), 32'({e_rd, e_rd}));
    check({tag, "_flush"}, 32'(flush_en), 32'(e_fl));
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Continuous valid beats; flush on every acc_len-th beat, tile i at base+i.
  task automatic run_beats(input int n, input int acc_len_eff, input logic [ADDR_W-1:0] base,
                           input string tag);
    bit fl;
    for (int i = 1; i <= n; i++) begin
      fl = (i % acc_len_eff) == 0;
      if (fl) exp_q.push_back(base + ADDR_W'(i / acc_len_eff - 1));
      drive(1'b1, 1'b0, 1'b1, fl, tag);
    end
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      ofifo_valid = 1'b0;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_acc_len   = '0;
    cfg_num_out   = '0;
    cfg_base_addr = '0;
    ofifo_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({ofifo_rd, acc_en, flush_en, out_valid, busy, done}), 32'd0);
    check("reset_addr", 32'(out_addr), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Job 1: acc_len=4, num_out=3, base 0x010, no bubbles; done 15 cycles after start.
    do_start(8'd4, 11'd3, 11'h010);
    run_beats(12, 4, 11'h010, "job1");
    for (int c = 13; c <= 16; c++) begin
      ofifo_valid = 1'b0;
      @(negedge clk);
      check("job1_done_time", 32'(done), 32'(c == 15));
      check("job1_busy_time", 32'(busy), 32'(c <= 15));
      @(posedge clk); #1;
    end
    check("job1_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of RUN with acc_cnt=2.
    do_start(8'd4, 11'd1, 11'h040);
    drive(1'b1, 1'b0, 1'b1, 1'b0, "rst_pre");
    drive(1'b1, 1'b0, 1'b1, 1'b0, "rst_pre");
    ofifo_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_ctrl", 32'({ofifo_rd, acc_en, flush_en, out_valid, busy, done}), 32'd0);
    check("midrun_reset_addr", 32'(out_addr), 32'd0);
    ofifo_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_start(8'd2, 11'd2, 11'h050);
    run_beats(4, 2, 11'h050, "after_rst");
    wait_done(6, "after_rst");
    check("after_rst_queue", 32'(exp_q.size()), 32'd0);

    // Job 2: acc_len=3 with bubbles 1,0,1,0,1; flush only on the 3rd valid beat.
    do_start(8'd3, 11'd1, 11'h020);
    drive(1'b1, 1'b0, 1'b1, 1'b0, "bub1");
    drive(1'b0, 1'b0, 1'b0, 1'b0, "bub2");
    drive(1'b1, 1'b0, 1'b1, 1'b0, "bub3");
    drive(1'b0, 1'b0, 1'b0, 1'b0, "bub4");
    exp_q.push_back(11'h020);
    drive(1'b1, 1'b0, 1'b1, 1'b1, "bub5");
    wait_done(8, "job2");
    check("job2_queue", 32'(exp_q.size()), 32'd0);

    // cfg_acc_len=0 behaves as 1: back-to-back flushes and writes.
    do_start(8'd0, 11'd2, 11'h030);
    run_beats(2, 1, 11'h030, "acc0");
    wait_done(6, "acc0");
    check("acc0_queue", 32'(exp_q.size()), 32'd0);

    // num_out=0: done two cycles after start, never any strobe.
    do_start(8'd4, 11'd0, 11'h040);
    drive(1'b1, 1'b0, 1'b0, 1'b0, "nout0_c1");
    ofifo_valid = 1'b1;
    @(negedge clk);
    check("nout0_done", 32'(done), 32'd1);
    check("nout0_strobes", 32'({ofifo_rd, acc_en, flush_en}), 32'd0);
    @(posedge clk); #1;
    ofifo_valid = 1'b0;
    check("nout0_busy_fall", 32'(busy), 32'd0);

    // Abort after 2 of 4 beats: abort beat suppressed, then a clearing flush.
    do_start(8'd4, 11'd2, 11'h060);
    drive(1'b1, 1'b0, 1'b1, 1'b0, "abt_b1");
    drive(1'b1, 1'b0, 1'b1, 1'b0, "abt_b2");
    drive(1'b1, 1'b1, 1'b0, 1'b0, "abt_cyc");
    ofifo_valid = 1'b0;
    @(negedge clk);
    check("abort_flush", 32'({flush_en, acc_en, ofifo_rd}), 32'b100);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_quiet", 32'({flush_en, done, busy}), 32'd0);
      @(posedge clk); #1;
    end

    // Address wrap at 0x7FF; a start during RUN is ignored.
    do_start(8'd1, 11'd2, 11'h7FF);
    exp_q.push_back(11'h7FF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, "wrap1");
    exp_q.push_back(11'h000);
    cfg_acc_len   = 8'd4;
    cfg_num_out   = 11'd5;
    cfg_base_addr = 11'h100;
    start         = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, "wrap2");
    start = 1'b0;
    wait_done(6, "wrap");
    repeat (3) begin
      @(negedge clk);
      check("wrap_idle", 32'({busy, ofifo_rd}), 32'd0);
      @(posedge clk); #1;
    end
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
